// File: rtl/ram_arb_bridge_pkg.sv
// Shared types and constants for the RAMHelper arbitration bridge.
// Response checking in the top is enabled by defining RAM_ARB_BRIDGE_CHECK_EN.
package ram_arb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [63:0] PC_START = 64'h8000_0000;

  // Access size encodings carried on ch_size_i (log2 of bytes)
  localparam logic [2:0] SIZE_B = 3'd0;
  localparam logic [2:0] SIZE_H = 3'd1;
  localparam logic [2:0] SIZE_W = 3'd2;
  localparam logic [2:0] SIZE_D = 3'd3;

  function automatic int bit_mask_w(input int byte_mask_w);
    return byte_mask_w * 8;
  endfunction

endpackage

// File: rtl/ram_arb_bridge_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr.
module rr_arbiter #(
  parameter int NCH = 2,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan channels starting at ptr, wrapping modulo NCH
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    cand    = '0;
    found   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      cand = IW'((32'(ptr) + 32'(i)) % 32'(NCH));
      if (!found && req[cand]) begin
        found       = 1'b1;
        gnt_idx     = cand;
        gnt[cand]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_arb_bridge.sv
// Arbitrates NCH core request channels onto the single-ported RAMHelper.
// Optional address/alignment checking is enabled by RAM_ARB_BRIDGE_CHECK_EN.
module ram_arb_bridge
  import ram_arb_bridge_pkg::*;
#(
  parameter int          NCH    = 2,
  parameter int          DATA_W = 64,
  parameter int          IDX_W  = 16,
  parameter logic [63:0] BASE   = PC_START,
  parameter int          LAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCH-1:0]           ch_cen_i,
  input  logic [NCH-1:0]           ch_wen_i,
  input  logic [NCH*64-1:0]        ch_addr_i,
  input  logic [NCH*DATA_W-1:0]    ch_wdata_i,
  input  logic [NCH*(DATA_W/8)-1:0] ch_wmask_i,
  input  logic [NCH*3-1:0]         ch_size_i,
  output logic [NCH-1:0]           ch_ready_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic [NCH-1:0]           ch_err_o,
  output logic                     ram_en_o,
  output logic                     ram_wen_o,
  output logic [IDX_W-1:0]         ram_idx_o,
  output logic [DATA_W-1:0]        ram_wdata_o,
  output logic [DATA_W-1:0]        ram_wmask_o,
  input  logic [DATA_W-1:0]        ram_rdata_i
);

  localparam int MW  = DATA_W / 8;
  localparam int BMW = bit_mask_w(MW);
  localparam int SH  = $clog2(MW);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     gnt_q;
  logic [3:0]        cnt;
  logic [NCH-1:0]    ready_q;
  logic [NCH-1:0]    err_q;
  logic              err_pend;
  logic [DATA_W-1:0] rdata_q;

  logic [NCH-1:0]    gnt_oh;
  logic [IW-1:0]     gnt_idx;
  logic [IW-1:0]     next_ptr;
  logic              any_req;
  logic              access;
  logic              acc_err;
  logic              sel_wen;
  logic [63:0]       sel_addr;
  logic [63:0]       offset;
  logic [DATA_W-1:0] sel_wdata;
  logic [MW-1:0]     sel_wmask;
  logic [BMW-1:0]    sel_bitmask;
  logic [2:0]        sel_size;
  logic              unused_bits;

  rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .req     (ch_cen_i),
    .ptr     (rr_ptr),
    .gnt     (gnt_oh),
    .gnt_idx (gnt_idx)
  );

  // Pick the granted channel's request fields
  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wmask = '0;
    sel_size  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (IW'(c) == gnt_idx) begin
        sel_wen   = ch_wen_i[c];
        sel_addr  = ch_addr_i[c*64 +: 64];
        sel_wdata = ch_wdata_i[c*DATA_W +: DATA_W];
        sel_wmask = ch_wmask_i[c*MW +: MW];
        sel_size  = ch_size_i[c*3 +: 3];
      end
    end
  end

  always_comb begin
    sel_bitmask = '0;
    for (int i = 0; i < MW; i++) begin
      sel_bitmask[8*i +: 8] = {8{sel_wmask[i]}};
    end
  end

  assign offset   = sel_addr - BASE;
  assign any_req  = |ch_cen_i;
  assign access   = rst_n && (state == IDLE) && any_req;
  assign next_ptr = (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;

`ifdef RAM_ARB_BRIDGE_CHECK_EN
  logic [63:0] align_mask;

  // Below BASE, beyond the RAMHelper window, or not naturally aligned
  assign align_mask  = (64'd1 << sel_size) - 64'd1;
  assign acc_err     = (sel_addr < BASE) ||
                       ((offset >> (IDX_W + SH)) != 64'd0) ||
                       ((sel_addr & align_mask) != 64'd0);
  assign unused_bits = ^{offset[SH-1:0]};
`else
  assign acc_err     = 1'b0;
  assign unused_bits = ^{offset[SH-1:0], offset[63:IDX_W+SH], sel_size};
`endif

  assign ram_en_o    = access && !acc_err;
  assign ram_wen_o   = ram_en_o && sel_wen;
  assign ram_idx_o   = access ? offset[SH +: IDX_W] : '0;
  assign ram_wdata_o = access ? sel_wdata : '0;
  assign ram_wmask_o = access ? sel_bitmask : '0;

  assign ch_ready_o  = ready_q;
  assign ch_err_o    = err_q;
  assign ch_rdata_o  = rdata_q;

  // One RAM access per grant; ready/err are single-cycle pulses on entry to RESP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      cnt      <= '0;
      ready_q  <= '0;
      err_q    <= '0;
      err_pend <= 1'b0;
      rdata_q  <= '0;
    end else begin
      ready_q <= '0;
      err_q   <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= gnt_idx;
            rr_ptr   <= next_ptr;
            err_pend <= acc_err;
            rdata_q  <= (sel_wen || acc_err) ? '0 : ram_rdata_i;
            if (LAT == 1) begin
              state   <= RESP;
              ready_q <= gnt_oh;
              err_q   <= acc_err ? gnt_oh : '0;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LAT - 2);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            ready_q <= NCH'(1) << gnt_q;
            err_q   <= err_pend ? (NCH'(1) << gnt_q) : '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb_bridge.sv
// Directed self-checking bench: a LAT=1 and a LAT=4 bridge, each with its own RAM model.
module tb_ram_arb_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic load;

  logic [1:0]   cen1, wen1, ready1, err1;
  logic [127:0] addr1, wdata1;
  logic [15:0]  wmask1, idx1;
  logic [5:0]   size1;
  logic [63:0]  rdata1, wd1, wm1, rd1;
  logic         en1, we1;

  logic [1:0]   cen4, wen4, ready4, err4;
  logic [127:0] addr4, wdata4;
  logic [15:0]  wmask4, idx4;
  logic [5:0]   size4;
  logic [63:0]  rdata4, wd4, wm4, rd4;
  logic         en4, we4;

  logic [63:0] mem1 [0:255];
  logic [63:0] mem4 [0:255];
  int wr1 = 0;
  int wr4 = 0;

  int checks = 0;
  int errors = 0;

  function automatic logic [63:0] init_word(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h0BEE_0000 + 32'(i)};
  endfunction

  ram_arb_bridge #(.NCH(2), .DATA_W(64), .IDX_W(16), .BASE(64'h8000_0000), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .ch_cen_i(cen1), .ch_wen_i(wen1), .ch_addr_i(addr1), .ch_wdata_i(wdata1),
    .ch_wmask_i(wmask1), .ch_size_i(size1),
    .ch_ready_o(ready1), .ch_rdata_o(rdata1), .ch_err_o(err1),
    .ram_en_o(en1), .ram_wen_o(we1), .ram_idx_o(idx1), .ram_wdata_o(wd1),
    .ram_wmask_o(wm1), .ram_rdata_i(rd1)
  );

  ram_arb_bridge #(.NCH(2), .DATA_W(64), .IDX_W(16), .BASE(64'h8000_0000), .LAT(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .ch_cen_i(cen4), .ch_wen_i(wen4), .ch_addr_i(addr4), .ch_wdata_i(wdata4),
    .ch_wmask_i(wmask4), .ch_size_i(size4),
    .ch_ready_o(ready4), .ch_rdata_o(rdata4), .ch_err_o(err4),
    .ram_en_o(en4), .ram_wen_o(we4), .ram_idx_o(idx4), .ram_wdata_o(wd4),
    .ram_wmask_o(wm4), .ram_rdata_i(rd4)
  );

  assign rd1 = mem1[idx1[7:0]];
  assign rd4 = mem4[idx4[7:0]];

  // RAMHelper models: combinational read, bit-masked write on the clock edge
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
    end else if (en1 && we1) begin
      mem1[idx1[7:0]] <= (mem1[idx1[7:0]] & ~wm1) | (wd1 & wm1);
      wr1 <= wr1 + 1;
    end
  end

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem4[i] <= init_word(i);
    end else if (en4 && we4) begin
      mem4[idx4[7:0]] <= (mem4[idx4[7:0]] & ~wm4) | (wd4 & wm4);
      wr4 <= wr4 + 1;
    end
  end

  task automatic set_ch(input bit d4, input int ch, input bit cen, input bit wen,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] wmask, input logic [2:0] size);
    if (d4) begin
      cen4[ch] = cen; wen4[ch] = wen; addr4[ch*64 +: 64] = addr;
      wdata4[ch*64 +: 64] = wdata; wmask4[ch*8 +: 8] = wmask; size4[ch*3 +: 3] = size;
    end else begin
      cen1[ch] = cen; wen1[ch] = wen; addr1[ch*64 +: 64] = addr;
      wdata1[ch*64 +: 64] = wdata; wmask1[ch*8 +: 8] = wmask; size1[ch*3 +: 3] = size;
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b1;
    set_ch(0, 0, 1, 1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 3'd3);
    set_ch(0, 1, 1, 0, 64'h8000_0010, 64'h0, 8'h00, 3'd3);
    next_cycle();
    next_cycle();
    load = 1'b0;
    checks++; if (en1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_en1 got %b exp 0", en1); end
    checks++; if (we1 !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen1 got %b exp 0", we1); end
    checks++; if (idx1 !== 16'd0) begin errors++; $display("[TB] FAIL reset_idx1 got %h exp 0", idx1); end
    checks++; if (wd1 !== 64'd0 || wm1 !== 64'd0) begin errors++; $display("[TB] FAIL reset_wdata_wmask got %h/%h exp 0/0", wd1, wm1); end
    checks++; if (ready1 !== 2'b00 || err1 !== 2'b00) begin errors++; $display("[TB] FAIL reset_ready_err1 got %b/%b exp 00/00", ready1, err1); end
    checks++; if (rdata1 !== 64'd0) begin errors++; $display("[TB] FAIL reset_rdata1 got %h exp 0", rdata1); end
    checks++; if (ready4 !== 2'b00 || en4 !== 1'b0) begin errors++; $display("[TB] FAIL reset_dut4 got ready %b en %b exp 00/0", ready4, en4); end
    cen1  = 2'b00;
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_read();
    set_ch(0, 0, 1, 0, 64'h8000_0008, 64'h0, 8'h00, 3'd3);
    #1;
    checks++; if (en1 !== 1'b1) begin errors++; $display("[TB] FAIL rd_en got %b exp 1", en1); end
    checks++; if (we1 !== 1'b0) begin errors++; $display("[TB] FAIL rd_wen got %b exp 0", we1); end
    checks++; if (idx1 !== 16'd1) begin errors++; $display("[TB] FAIL rd_idx got %h exp 1", idx1); end
    next_cycle();
    checks++; if (ready1 !== 2'b01) begin errors++; $display("[TB] FAIL rd_ready got %b exp 01", ready1); end
    checks++; if (rdata1 !== init_word(1)) begin errors++; $display("[TB] FAIL rd_data got %h exp %h", rdata1, init_word(1)); end
    checks++; if (err1 !== 2'b00) begin errors++; $display("[TB] FAIL rd_err got %b exp 00", err1); end
    checks++; if (en1 !== 1'b0) begin errors++; $display("[TB] FAIL rd_en_resp got %b exp 0", en1); end
    cen1 = 2'b00;
    next_cycle();
    checks++; if (ready1 !== 2'b00) begin errors++; $display("[TB] FAIL rd_ready_pulse got %b exp 00", ready1); end
  endtask

  task automatic test_write_readback();
    logic [63:0] old;
    set_ch(0, 1, 1, 1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'h0F, 3'd3);
    #1;
    checks++; if (we1 !== 1'b1 || en1 !== 1'b1) begin errors++; $display("[TB] FAIL wr_en got %b/%b exp 1/1", en1, we1); end
    checks++; if (idx1 !== 16'd2) begin errors++; $display("[TB] FAIL wr_idx got %h exp 2", idx1); end
    checks++; if (wm1 !== 64'h0000_0000_FFFF_FFFF) begin errors++; $display("[TB] FAIL wr_mask got %h exp 00000000ffffffff", wm1); end
    checks++; if (wd1 !== 64'h1122_3344_5566_7788) begin errors++; $display("[TB] FAIL wr_data got %h exp 1122334455667788", wd1); end
    next_cycle();
    checks++; if (ready1 !== 2'b10) begin errors++; $display("[TB] FAIL wr_ready got %b exp 10", ready1); end
    checks++; if (rdata1 !== 64'd0) begin errors++; $display("[TB] FAIL wr_rdata got %h exp 0", rdata1); end
    cen1 = 2'b00;
    next_cycle();
    set_ch(0, 1, 1, 0, 64'h8000_0010, 64'h0, 8'h00, 3'd3);
    next_cycle();
    old = init_word(2);
    checks++; if (ready1 !== 2'b10) begin errors++; $display("[TB] FAIL rb_ready got %b exp 10", ready1); end
    checks++; if (rdata1 !== {old[63:32], 32'h5566_7788}) begin errors++; $display("[TB] FAIL rb_data got %h exp %h", rdata1, {old[63:32], 32'h5566_7788}); end
    cen1 = 2'b00;
    next_cycle();
  endtask

  task automatic test_contention();
    int exp_ch;
    set_ch(0, 0, 1, 0, 64'h8000_0020, 64'h0, 8'h00, 3'd3);
    set_ch(0, 1, 1, 0, 64'h8000_0028, 64'h0, 8'h00, 3'd3);
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_ch = k % 2;
      checks++; if (en1 !== 1'b1 || idx1 !== 16'(4 + exp_ch)) begin errors++; $display("[TB] FAIL cont_grant%0d got en %b idx %0d exp 1/%0d", k, en1, idx1, 4 + exp_ch); end
      next_cycle();
      checks++; if (ready1 !== 2'(1 << exp_ch)) begin errors++; $display("[TB] FAIL cont_ready%0d got %b exp %b", k, ready1, 2'(1 << exp_ch)); end
      checks++; if (rdata1 !== init_word(4 + exp_ch)) begin errors++; $display("[TB] FAIL cont_data%0d got %h exp %h", k, rdata1, init_word(4 + exp_ch)); end
      next_cycle();
    end
    cen1 = 2'b00;
    next_cycle();
  endtask

  task automatic test_lat4();
    int wr_before;
    set_ch(1, 0, 1, 0, 64'h8000_0018, 64'h0, 8'h00, 3'd3);
    #1;
    for (int c = 0; c < 6; c++) begin
      checks++; if (ready4 !== ((c == 4) ? 2'b01 : 2'b00)) begin errors++; $display("[TB] FAIL lat4_ready_c%0d got %b", c, ready4); end
      checks++; if (en4 !== ((c == 0) || (c == 5))) begin errors++; $display("[TB] FAIL lat4_en_c%0d got %b", c, en4); end
      if (c == 4) begin
        checks++; if (rdata4 !== init_word(3)) begin errors++; $display("[TB] FAIL lat4_data got %h exp %h", rdata4, init_word(3)); end
      end
      if (c < 5) next_cycle();
    end
    cen4 = 2'b00;
    next_cycle();
    wr_before = wr4;
    set_ch(1, 1, 1, 1, 64'h8000_0030, 64'hCAFE_F00D_1234_5678, 8'hFF, 3'd3);
    #1;
    for (int c = 0; c < 4; c++) next_cycle();
    checks++; if (ready4 !== 2'b10) begin errors++; $display("[TB] FAIL lat4_wr_ready got %b exp 10", ready4); end
    cen4 = 2'b00;
    next_cycle();
    checks++; if (wr4 - wr_before !== 1) begin errors++; $display("[TB] FAIL lat4_wr_count got %0d exp 1", wr4 - wr_before); end
    checks++; if (mem4[6] !== 64'hCAFE_F00D_1234_5678) begin errors++; $display("[TB] FAIL lat4_wr_mem got %h exp cafef00d12345678", mem4[6]); end
  endtask

  task automatic test_reset_mid_wait();
    set_ch(1, 0, 1, 0, 64'h8000_0038, 64'h0, 8'h00, 3'd3);
    next_cycle();
    next_cycle();
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      checks++; if (ready4 !== 2'b00 || en4 !== 1'b0 || idx4 !== 16'd0) begin errors++; $display("[TB] FAIL rstw_outs%0d got ready %b en %b idx %h", c, ready4, en4, idx4); end
      checks++; if (rdata4 !== 64'd0 || err4 !== 2'b00) begin errors++; $display("[TB] FAIL rstw_data%0d got %h/%b exp 0/00", c, rdata4, err4); end
    end
    set_ch(1, 1, 1, 0, 64'h8000_0040, 64'h0, 8'h00, 3'd3);
    rst_n = 1'b1;
    #1;
    checks++; if (en4 !== 1'b1 || idx4 !== 16'd7) begin errors++; $display("[TB] FAIL rstw_gnt got en %b idx %0d exp 1/7", en4, idx4); end
    for (int c = 0; c < 4; c++) next_cycle();
    checks++; if (ready4 !== 2'b01) begin errors++; $display("[TB] FAIL rstw_ready got %b exp 01", ready4); end
    checks++; if (rdata4 !== init_word(7)) begin errors++; $display("[TB] FAIL rstw_rdata got %h exp %h", rdata4, init_word(7)); end
    cen4 = 2'b00;
    for (int c = 0; c < 6; c++) next_cycle();
  endtask

`ifdef RAM_ARB_BRIDGE_CHECK_EN
  task automatic test_check_en();
    set_ch(0, 0, 1, 0, 64'h7FFF_FFF8, 64'h0, 8'h00, 3'd3);
    #1;
    checks++; if (en1 !== 1'b0) begin errors++; $display("[TB] FAIL chk_low_en got %b exp 0", en1); end
    next_cycle();
    checks++; if (ready1 !== 2'b01 || err1 !== 2'b01) begin errors++; $display("[TB] FAIL chk_low_resp got %b/%b exp 01/01", ready1, err1); end
    checks++; if (rdata1 !== 64'd0) begin errors++; $display("[TB] FAIL chk_low_data got %h exp 0", rdata1); end
    cen1 = 2'b00;
    next_cycle();
    set_ch(0, 1, 1, 0, 64'h8000_0004, 64'h0, 8'h00, 3'd3);
    #1;
    checks++; if (en1 !== 1'b0) begin errors++; $display("[TB] FAIL chk_align_en got %b exp 0", en1); end
    next_cycle();
    checks++; if (ready1 !== 2'b10 || err1 !== 2'b10) begin errors++; $display("[TB] FAIL chk_align_resp got %b/%b exp 10/10", ready1, err1); end
    checks++; if (rdata1 !== 64'd0) begin errors++; $display("[TB] FAIL chk_align_data got %h exp 0", rdata1); end
    cen1 = 2'b00;
    next_cycle();
    set_ch(0, 0, 1, 0, 64'h8000_0004, 64'h0, 8'h00, 3'd2);
    #1;
    checks++; if (en1 !== 1'b1) begin errors++; $display("[TB] FAIL chk_word_en got %b exp 1", en1); end
    next_cycle();
    checks++; if (err1 !== 2'b00 || ready1 !== 2'b01) begin errors++; $display("[TB] FAIL chk_word_resp got %b/%b exp 01/00", ready1, err1); end
    cen1 = 2'b00;
    next_cycle();
  endtask
`endif

  initial begin
    rst_n  = 1'b0;
    load   = 1'b0;
    cen1   = '0; wen1 = '0; addr1 = '0; wdata1 = '0; wmask1 = '0; size1 = '0;
    cen4   = '0; wen4 = '0; addr4 = '0; wdata4 = '0; wmask4 = '0; size4 = '0;
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_lat4();
    test_reset_mid_wait();
`ifdef RAM_ARB_BRIDGE_CHECK_EN
    test_check_en();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
